// File: rtl/vertex_unpack_stage.sv
// Registered vertex unpack: clamps NUM_VERTS (x,y) pairs to signed COORD_W, passes attributes, queues in a DEPTH FIFO.
// Optional macro VUNPACK_CULL_DEGENERATE_EN drops zero-area triangles (NUM_VERTS==3) and counts them in cull_cnt.
module vertex_unpack_stage #(
  parameter int WORD_W    = 32,
  parameter int IN_WORDS  = 15,
  parameter int NUM_VERTS = 3,
  parameter int COORD_W   = 10,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [WORD_W*IN_WORDS-1:0]                in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_VERTS*COORD_W-1:0]              out_vx,
  output logic [NUM_VERTS*COORD_W-1:0]              out_vy,
  output logic [WORD_W*(IN_WORDS-2*NUM_VERTS)-1:0]  out_attr,
  output logic [2*NUM_VERTS-1:0]                    out_ovf,
  output logic [CNT_W-1:0]                          prim_cnt,
  output logic [CNT_W-1:0]                          ovf_cnt,
  output logic [CNT_W-1:0]                          cull_cnt
);

  localparam int CW = NUM_VERTS * COORD_W;
  localparam int AW = WORD_W * (IN_WORDS - 2 * NUM_VERTS);
  localparam int OW = 2 * NUM_VERTS;
  localparam int EW = OW + AW + 2 * CW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Returns {ovf, clamped coordinate}; words already in range keep their low bits.
  function automatic logic [COORD_W:0] clamp_coord(input logic signed [WORD_W-1:0] val);
    logic signed [WORD_W-1:0] max_v;
    logic signed [WORD_W-1:0] min_v;
    max_v = $signed(WORD_W'((1 << (COORD_W - 1)) - 1));
    min_v = ~max_v;
    if (val > max_v)      return {1'b1, max_v[COORD_W-1:0]};
    else if (val < min_v) return {1'b1, min_v[COORD_W-1:0]};
    else                  return {1'b0, val[COORD_W-1:0]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    return (en && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  logic [COORD_W:0]  cx_p0 [NUM_VERTS];
  logic [COORD_W:0]  cy_p0 [NUM_VERTS];
  logic [CW-1:0]     vx_p0, vy_p0;
  logic [OW-1:0]     ovf_p0;
  logic [AW-1:0]     attr_p0;
  logic [EW-1:0]     entry_p0;
  logic              degen_p0;
  logic              accept, push, pop;

  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, head_idx;
  logic [PW:0]       count_q, count_d;
  logic [CNT_W-1:0]  prim_cnt_q, prim_cnt_d, ovf_cnt_q, ovf_cnt_d;

  // Stage p0: unpack and clamp the incoming record
  always_comb begin
    vx_p0  = '0;
    vy_p0  = '0;
    ovf_p0 = '0;
    for (int v = 0; v < NUM_VERTS; v++) begin
      cx_p0[v] = clamp_coord($signed(in_data[(2*v)*WORD_W +: WORD_W]));
      cy_p0[v] = clamp_coord($signed(in_data[(2*v+1)*WORD_W +: WORD_W]));
      vx_p0[v*COORD_W +: COORD_W] = cx_p0[v][COORD_W-1:0];
      vy_p0[v*COORD_W +: COORD_W] = cy_p0[v][COORD_W-1:0];
      ovf_p0[2*v]   = cx_p0[v][COORD_W];
      ovf_p0[2*v+1] = cy_p0[v][COORD_W];
    end
    attr_p0  = in_data[2*NUM_VERTS*WORD_W +: AW];
    entry_p0 = {ovf_p0, attr_p0, vy_p0, vx_p0};
  end

`ifdef VUNPACK_CULL_DEGENERATE_EN
  localparam int AREA_W = 2 * COORD_W + 3;

  logic signed [AREA_W-1:0] ax_p0 [3];
  logic signed [AREA_W-1:0] ay_p0 [3];
  logic signed [AREA_W-1:0] area_p0;
  logic [CNT_W-1:0]         cull_cnt_q, cull_cnt_d;

  always_comb begin
    for (int v = 0; v < 3; v++) begin
      ax_p0[v] = {{(AREA_W-COORD_W){vx_p0[v*COORD_W+COORD_W-1]}}, vx_p0[v*COORD_W +: COORD_W]};
      ay_p0[v] = {{(AREA_W-COORD_W){vy_p0[v*COORD_W+COORD_W-1]}}, vy_p0[v*COORD_W +: COORD_W]};
    end
    area_p0  = (ax_p0[1] - ax_p0[0]) * (ay_p0[2] - ay_p0[0])
             - (ax_p0[2] - ax_p0[0]) * (ay_p0[1] - ay_p0[0]);
    degen_p0 = (area_p0 == '0);
    cull_cnt_d = sat_inc(cull_cnt_q, accept & degen_p0);
  end

  always_ff @(posedge clk) begin
    if (rst) cull_cnt_q <= '0;
    else     cull_cnt_q <= cull_cnt_d;
  end

  assign cull_cnt = cull_cnt_q;
`else
  assign degen_p0 = 1'b0;
  assign cull_cnt = '0;
`endif

  assign in_ready  = (count_q < (PW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~degen_p0;
  assign pop       = out_valid & out_ready;

  // When empty, keep showing the most recently popped slot so outputs hold their last value.
  assign head_idx = out_valid ? rd_ptr_q : rd_ptr_q - PW'(1);
  assign {out_ovf, out_attr, out_vy, out_vx} = mem_q[head_idx];
  assign prim_cnt = prim_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = entry_p0;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
    prim_cnt_d = sat_inc(prim_cnt_q, accept);
    ovf_cnt_d  = sat_inc(ovf_cnt_q, accept & (|ovf_p0));
  end

  // Stage p1: FIFO storage and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      prim_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      prim_cnt_q <= prim_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

endmodule

// File: tb/tb_vertex_unpack_stage.sv
// Bench for vertex_unpack_stage: vector table, directed flow-control sequences, and a randomized queue-model run.
module tb_vertex_unpack_stage;
  localparam int WORD_W = 32, IN_WORDS = 15, NUM_VERTS = 3, COORD_W = 10, DEPTH = 2, CNT_W = 16;
  localparam int DW = WORD_W * IN_WORDS;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [29:0] out_vx, out_vy;
  logic [287:0] out_attr;
  logic [5:0] out_ovf;
  logic [CNT_W-1:0] prim_cnt, ovf_cnt, cull_cnt;

  vertex_unpack_stage #(.WORD_W(WORD_W), .IN_WORDS(IN_WORDS), .NUM_VERTS(NUM_VERTS),
                        .COORD_W(COORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_vx(out_vx), .out_vy(out_vy),
    .out_attr(out_attr), .out_ovf(out_ovf), .prim_cnt(prim_cnt), .ovf_cnt(ovf_cnt),
    .cull_cnt(cull_cnt));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { int w[6]; logic [29:0] vx; logic [29:0] vy; logic [5:0] ovf; } vec_t;
  typedef struct { logic [29:0] vx; logic [29:0] vy; logic [5:0] ovf; logic [287:0] attr; } exp_t;

  vec_t vec[4];
  exp_t q[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkrec(input int w0, w1, w2, w3, w4, w5, input int tag);
    logic [DW-1:0] d;
    d[31:0] = w0; d[63:32] = w1; d[95:64] = w2; d[127:96] = w3; d[159:128] = w4; d[191:160] = w5;
    for (int k = 6; k < IN_WORDS; k++) d[k*32 +: 32] = 32'hA000_0000 + (tag << 8) + k;
    return d;
  endfunction

  // Clamp a signed integer into the 10-bit signed range, reporting saturation.
  function automatic longint clampw(input longint v, output bit o);
    o = 1'b1;
    if (v > 511) return 511;
    if (v < -512) return -512;
    o = 1'b0;
    return v;
  endfunction

  function automatic exp_t ref_model(input logic [DW-1:0] d, output bit degen);
    exp_t e;
    longint cx[3], cy[3];
    bit o;
    for (int v = 0; v < 3; v++) begin
      cx[v] = clampw(longint'($signed(d[64*v +: 32])), o);
      e.ovf[2*v] = o;
      cy[v] = clampw(longint'($signed(d[64*v+32 +: 32])), o);
      e.ovf[2*v+1] = o;
      e.vx[10*v +: 10] = cx[v][9:0];
      e.vy[10*v +: 10] = cy[v][9:0];
    end
    e.attr = d[DW-1:192];
    degen = ((cx[1]-cx[0])*(cy[2]-cy[0]) - (cx[2]-cx[0])*(cy[1]-cy[0])) == 0;
    return e;
  endfunction

  function automatic int rw();
    int b[6] = '{511, 512, -512, -513, 0, -1};
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 1200)) - 600;
      1: return int'($urandom);
      2: return b[$urandom_range(0, 5)];
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  // Non-degenerate triangle tagged by its x0 value.
  function automatic logic [DW-1:0] tagrec(input int x0);
    return mkrec(x0, 0, x0 + 5, 0, x0, 7, x0);
  endfunction

  int exp_prim, exp_ovf, exp_cull;
  bit cull_en, mready, dg;
  exp_t e;

  initial begin
`ifdef VUNPACK_CULL_DEGENERATE_EN
    cull_en = 1'b1;
`else
    cull_en = 1'b0;
`endif
    vec[0].w = '{20, 20, 30, 20, 25, 30};
    vec[0].vx = {10'd25, 10'd30, 10'd20}; vec[0].vy = {10'd30, 10'd20, 10'd20}; vec[0].ovf = 6'b000000;
    vec[1].w = '{600, 0, 0, -700, 0, 5};
    vec[1].vx = {10'd0, 10'd0, 10'd511}; vec[1].vy = {10'd5, 10'h200, 10'd0}; vec[1].ovf = 6'b001001;
    vec[2].w = '{511, -512, 512, -513, -1, 0};
    vec[2].vx = {10'h3FF, 10'd511, 10'd511}; vec[2].vy = {10'd0, 10'h200, 10'h200}; vec[2].ovf = 6'b001100;
    vec[3].w = '{32'h7FFF_FFFF, 32'h8000_0000, 1024, -1024, 100, -100};
    vec[3].vx = {10'd100, 10'd511, 10'd511}; vec[3].vy = {10'h39C, 10'h200, 10'h200}; vec[3].ovf = 6'b001111;

    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_prim_cnt", prim_cnt, 0);
    chk("rst_outputs", {out_ovf, out_attr, out_vy, out_vx}, 0);

    // Vector table, one record per cycle with the consumer always ready
    exp_prim = 0; exp_ovf = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = mkrec(vec[i].w[0], vec[i].w[1], vec[i].w[2], vec[i].w[3], vec[i].w[4], vec[i].w[5], i);
      in_valid = 1'b1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      exp_prim++;
      if (|vec[i].ovf) exp_ovf++;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_vx", i), out_vx, vec[i].vx);
      chk($sformatf("vec%0d_vy", i), out_vy, vec[i].vy);
      chk($sformatf("vec%0d_ovf", i), out_ovf, vec[i].ovf);
      chk($sformatf("vec%0d_attr", i), out_attr, in_data[DW-1:192]);
      chk($sformatf("vec%0d_prim_cnt", i), prim_cnt, exp_prim);
      chk($sformatf("vec%0d_ovf_cnt", i), ovf_cnt, exp_ovf);
    end
    tick();
    chk("vec_drained", out_valid, 0);
    chk("hold_last_vx", out_vx, vec[3].vx);

    // Backpressure: two fill the FIFO, the third waits, then A,B,C drain in order
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      in_data = tagrec(k);
      chk($sformatf("bp_in_ready%0d", k), in_ready, 1);
      tick();
    end
    in_data = tagrec(3);
    chk("bp_full_in_ready", in_ready, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_out_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_order%0d", k), out_vx[9:0], k + 1);
      if (k == 0) chk("bp_no_bypass", in_ready, 0);
      tick();
      if (k == 1) in_valid = 1'b0;
    end
    chk("bp_empty", out_valid, 0);

    // Streaming with one entry resident: push and pop every cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = tagrec(100);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = tagrec(101 + k);
      chk($sformatf("st_in_ready%0d", k), in_ready, 1);
      chk($sformatf("st_out_valid%0d", k), out_valid, 1);
      chk($sformatf("st_order%0d", k), out_vx[9:0], 100 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("st_count_one_valid", out_valid, 1);
    chk("st_count_one_head", out_vx[9:0], 108);
    tick();
    chk("st_count_one_drained", out_valid, 0);

    // Reset with two entries queued and a record offered in the reset cycle
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = tagrec(1); tick();
    in_data = tagrec(2); tick();
    rst = 1'b1;
    in_data = tagrec(3);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_prim_cnt", prim_cnt, 0);
    chk("rst2_ovf_cnt", ovf_cnt, 0);
    chk("rst2_cull_cnt", cull_cnt, 0);
    chk("rst2_out_vx", out_vx, 0);
    tick();
    chk("rst2_still_empty", out_valid, 0);

    // Colinear triangle
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = mkrec(0, 0, 10, 10, 20, 20, 9);
    tick();
    in_valid = 1'b0;
    chk("col_prim_cnt", prim_cnt, 1);
    chk("col_out_valid", out_valid, cull_en ? 0 : 1);
    chk("col_cull_cnt", cull_cnt, cull_en ? 1 : 0);
    tick();
    in_valid = 1'b1;
    in_data = mkrec(20, 20, 30, 20, 25, 30, 10);
    tick();
    in_valid = 1'b0;
    chk("col_next_valid", out_valid, 1);
    chk("col_next_vx", out_vx, vec[0].vx);
    chk("col_next_prim", prim_cnt, 2);
    tick();

    // Randomized traffic against the queue model
    rst = 1'b1; tick(); rst = 1'b0;
    q.delete();
    exp_prim = 0; exp_ovf = 0; exp_cull = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = mkrec(rw(), rw(), rw(), rw(), rw(), rw(), c);
      for (int k = 6; k < IN_WORDS; k++) in_data[k*32 +: 32] = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      mready = (q.size() < DEPTH);
      chk("rnd_in_ready", in_ready, mready);
      chk("rnd_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_head", {out_ovf, out_attr, out_vy, out_vx}, {q[0].ovf, q[0].attr, q[0].vy, q[0].vx});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && mready) begin
        e = ref_model(in_data, dg);
        exp_prim++;
        if (|e.ovf) exp_ovf++;
        if (cull_en && dg) exp_cull++;
        else q.push_back(e);
      end
      tick();
      chk("rnd_prim_cnt", prim_cnt, exp_prim);
    end
    in_valid = 1'b0;
    chk("rnd_ovf_cnt", ovf_cnt, exp_ovf);
    chk("rnd_cull_cnt", cull_cnt, exp_cull);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
